reset_sequencer: RTL and testbench

- Parametrised board-level reset generator for the ULX3S top.
- Qualifies N PLL lock inputs, a debounced active-low reset button and a software reset request, then releases M reset domains in a fixed staggered order.
- Reports the cause of the last reset; ready_o marks the fully released system.
- Sits between the PLLs/button pins and the SoC, USB host and PS/2 reset inputs. Generalises the simple power-on counter.

---
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Board reset sequencer: qualifies PLL locks, a debounced button and a software request,
// then releases reset domains in staggered order. Watchdog enabled by RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int NUM_LOCKS       = 2,
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 31,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WDT_CYCLES      = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [NUM_LOCKS-1:0]  locked_i,
  input  logic                  btn_n_i,
  input  logic                  sw_reset_i,
  input  logic                  wdt_kick_i,
  output logic [NUM_STAGES-1:0] reset_o,
  output logic                  ready_o,
  output logic [2:0]            cause_o
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [HOLD_W-1:0]     HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_MAX   = GAP_W'(STAGE_GAP - 1);
  localparam logic [DB_W-1:0]       DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_REL = ~NUM_STAGES'(1);

  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} state_e;
  typedef enum logic [2:0] {
    CAUSE_POR = 3'd0, CAUSE_LOCK = 3'd1, CAUSE_BTN = 3'd2, CAUSE_SW = 3'd3, CAUSE_WDT = 3'd4
  } cause_e;

  logic [NUM_LOCKS-1:0] lock_s1_q, lock_s2_q;
  logic                 btn_s1_q, btn_s2_q;
  logic                 btn_db_q, btn_db_d, btn_prev_q;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_s1_q  <= '0;
      lock_s2_q  <= '0;
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      btn_db_q   <= 1'b1;
      btn_prev_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      lock_s1_q  <= locked_i;
      lock_s2_q  <= lock_s1_q;
      btn_s1_q   <= btn_n_i;
      btn_s2_q   <= btn_s1_q;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_MAX) btn_db_d = btn_s2_q;
      else                    db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  state_e                state_q;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [NUM_STAGES-1:0] reset_q;
  logic                  ready_q;
  cause_e                cause_q;
  logic                  wdt_fire;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_cnt_q;

  assign wdt_fire = (state_q == ST_RUN) && !wdt_kick_i && (wdt_cnt_q == WDT_MAX);

  // Held at zero outside RUN, so it always starts fresh on entry to RUN.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)                          wdt_cnt_q <= '0;
    else if (state_q != ST_RUN || wdt_kick_i) wdt_cnt_q <= '0;
    else if (wdt_cnt_q != WDT_MAX)           wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
  end
`else
  logic unused_wdt;
  assign wdt_fire   = 1'b0;
  assign unused_wdt = wdt_kick_i ^ (WDT_CYCLES != 0);
`endif

  logic                  lock_ok, ok, press_evt, trig;
  cause_e                trig_cause;
  logic [NUM_STAGES-1:0] reset_next;

  always_comb begin
    lock_ok    = &lock_s2_q;
    ok         = lock_ok && btn_db_q;
    press_evt  = btn_prev_q && !btn_db_q;
    reset_next = reset_q << 1;
    trig       = 1'b1;
    trig_cause = CAUSE_LOCK;
    if      (!lock_ok)   trig_cause = CAUSE_LOCK;
    else if (press_evt)  trig_cause = CAUSE_BTN;
    else if (wdt_fire)   trig_cause = CAUSE_WDT;
    else if (sw_reset_i) trig_cause = CAUSE_SW;
    else                 trig       = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      reset_q    <= '1;
      ready_q    <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      case (state_q)
        ST_HOLD: begin
          reset_q   <= '1;
          ready_q   <= 1'b0;
          gap_cnt_q <= '0;
          if (!ok) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_MAX) begin
            hold_cnt_q <= '0;
            reset_q    <= FIRST_REL;
            if (FIRST_REL == '0) begin
              ready_q <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_RELEASE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (trig) begin
            reset_q    <= '1;
            ready_q    <= 1'b0;
            cause_q    <= trig_cause;
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
          end else if (state_q == ST_RELEASE) begin
            if (gap_cnt_q == GAP_MAX) begin
              gap_cnt_q <= '0;
              reset_q   <= reset_next;
              if (reset_next == '0) begin
                ready_q <= 1'b1;
                state_q <= ST_RUN;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign reset_o = reset_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal timing, then random stimulus,
// all compared every cycle against a release-count model. Watchdog part needs RESET_SEQ_WATCHDOG_EN.
module tb_reset_sequencer;
  localparam int NL = 2, NS = 3, HOLD = 8, GAP = 4, DB = 5, WDT = 20;

  logic          clk = 1'b0;
  logic          reset_n_i, btn_n_i, sw_reset_i, wdt_kick_i;
  logic [NL-1:0] locked_i;
  logic [NS-1:0] reset_o;
  logic          ready_o;
  logic [2:0]    cause_o;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_LOCKS(NL), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
    .DEBOUNCE_CYCLES(DB), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i), .locked_i(locked_i), .btn_n_i(btn_n_i),
    .sw_reset_i(sw_reset_i), .wdt_kick_i(wdt_kick_i),
    .reset_o(reset_o), .ready_o(ready_o), .cause_o(cause_o)
  );

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: synchronised views are the inputs two edges old; after qualification the
  // number of released stages is simply 1 + (cycles since first release) / GAP.
  logic [NL-1:0] m_lk1, m_lk2;
  logic          m_bt1, m_bt2, m_lvl, m_press;
  int            m_diff, m_okrun, m_t, m_idle;
  bit            m_seq;
  logic [2:0]    m_cause;
  logic [NS-1:0] exp_reset;
  logic          exp_ready;
  logic [2:0]    exp_cause;

  function automatic int released(input int t);
    int r = 1 + t / GAP;
    return (r > NS) ? NS : r;
  endfunction

  task automatic model_reset();
    m_lk1 = '0; m_lk2 = '0; m_bt1 = 1'b1; m_bt2 = 1'b1; m_lvl = 1'b1; m_press = 1'b0;
    m_diff = 0; m_okrun = 0; m_t = 0; m_idle = 0; m_seq = 1'b0; m_cause = 3'd0;
    exp_reset = '1; exp_ready = 1'b0; exp_cause = 3'd0;
  endtask

  task automatic model_step();
    bit lock_ok, running, fire_wdt, new_press;
    int tcause, r;
    if (!reset_n_i) begin
      model_reset();
      return;
    end
    lock_ok  = &m_lk2;
    running  = m_seq && (released(m_t) == NS);
    fire_wdt = 1'b0;
    if (!m_seq) begin
      if (lock_ok && m_lvl) begin
        m_okrun++;
        if (m_okrun == HOLD) begin m_seq = 1'b1; m_t = 0; m_idle = 0; end
      end else begin
        m_okrun = 0;
      end
    end else begin
`ifdef RESET_SEQ_WATCHDOG_EN
      if (running) begin
        if (wdt_kick_i) m_idle = 0;
        else            m_idle++;
        fire_wdt = (m_idle >= WDT);
      end
`endif
      if      (!lock_ok)   tcause = 1;
      else if (m_press)    tcause = 2;
      else if (fire_wdt)   tcause = 4;
      else if (sw_reset_i) tcause = 3;
      else                 tcause = 0;
      if (tcause != 0) begin
        m_seq = 1'b0; m_okrun = 0; m_cause = 3'(tcause);
      end else if (m_t < 1000000) begin
        m_t++;
      end
    end
    new_press = 1'b0;
    if (m_bt2 != m_lvl) begin
      m_diff++;
      if (m_diff == DB) begin m_lvl = m_bt2; m_diff = 0; new_press = !m_lvl; end
    end else begin
      m_diff = 0;
    end
    m_press = new_press;
    m_lk2 = m_lk1; m_lk1 = locked_i;
    m_bt2 = m_bt1; m_bt1 = btn_n_i;
    if (!m_seq) begin
      exp_reset = '1; exp_ready = 1'b0;
    end else begin
      r = released(m_t);
      exp_reset = '1;
      exp_reset = exp_reset << r;
      exp_ready = (r == NS);
    end
    exp_cause = m_cause;
  endtask

  // One clock: model advances on the edge, control returns at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (!ready_o && n < bound) begin cyc(); n++; end
    check(name, int'(ready_o), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("reset_o", int'(reset_o), int'(exp_reset));
        check("ready_o", int'(ready_o), int'(exp_ready));
        check("cause_o", int'(cause_o), int'(exp_cause));
      end
    end
  end

  initial begin
    int t0, t1, t2, lock_left, btn_left;
    bit kick_on;
    reset_n_i = 1'b0; locked_i = '1; btn_n_i = 1'b1; sw_reset_i = 1'b0; wdt_kick_i = 1'b0;
    model_reset();
    repeat (3) cyc();
    reset_n_i = 1'b1;
    chk_en = 1'b1;

    // Power-on release timing
    t0 = -1; t1 = -1; t2 = -1;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (t0 < 0 && !reset_o[0]) t0 = n;
      if (t1 < 0 && !reset_o[1]) t1 = n;
      if (t2 < 0 && !reset_o[2] && ready_o) t2 = n;
    end
    check("por_stage0_cycle", t0, 10);
    check("por_stage1_cycle", t1, 14);
    check("por_stage2_cycle", t2, 18);
    check("por_cause", int'(cause_o), 0);

    // One-cycle lock loss in RUN
    locked_i = 2'b01; cyc(); locked_i = 2'b11; cyc();
    check("lock_not_early", int'(reset_o), 0);
    cyc();
    check("lock_reset", int'(reset_o), 7);
    check("lock_ready", int'(ready_o), 0);
    check("lock_cause", int'(cause_o), 1);
    t0 = -1;
    for (int n = 4; n <= 40; n++) begin
      cyc();
      if (t0 < 0 && !reset_o[0]) t0 = n;
    end
    check("lock_rerelease_cycle", t0, 11);

    // Button glitch, then a real press
    btn_n_i = 1'b0; repeat (3) cyc(); btn_n_i = 1'b1; repeat (20) cyc();
    check("glitch_no_reset", int'(reset_o), 0);
    check("glitch_ready", int'(ready_o), 1);
    btn_n_i = 1'b0; t0 = -1; t1 = -1;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (n == 6) btn_n_i = 1'b1;
      if (t0 < 0 && reset_o == 3'b111) begin
        t0 = n;
        check("btn_cause", int'(cause_o), 2);
      end
      if (t0 > 0 && t1 < 0 && !reset_o[0]) t1 = n;
    end
    check("btn_reset_cycle", t0, 8);
    check("btn_release_cycle", t1, 21);
    wait_ready("btn_ready", 40);

    // Software reset in RUN, then again in RELEASE right after stage 0
    sw_reset_i = 1'b1; cyc(); sw_reset_i = 1'b0;
    check("sw_run_reset", int'(reset_o), 7);
    check("sw_run_cause", int'(cause_o), 3);
    t0 = -1;
    for (int n = 1; n <= 20 && t0 < 0; n++) begin cyc(); if (reset_o == 3'b110) t0 = n; end
    check("sw_run_rerelease", t0, 8);
    sw_reset_i = 1'b1; cyc(); sw_reset_i = 1'b0;
    check("sw_rel_reset", int'(reset_o), 7);
    check("sw_rel_cause", int'(cause_o), 3);
    t0 = -1;
    for (int n = 1; n <= 20 && t0 < 0; n++) begin cyc(); if (!reset_o[0]) t0 = n; end
    check("sw_rel_rerelease", t0, 8);
    wait_ready("sw_ready", 40);

    // Lock loss and software request reaching the sequencer on the same edge
    locked_i = 2'b10; cyc(); locked_i = 2'b11; cyc();
    sw_reset_i = 1'b1; cyc(); sw_reset_i = 1'b0;
    check("both_reset", int'(reset_o), 7);
    check("both_cause", int'(cause_o), 1);
    wait_ready("both_ready", 40);

`ifdef RESET_SEQ_WATCHDOG_EN
    for (int k = 0; k < 4; k++) begin
      wdt_kick_i = 1'b1; cyc(); wdt_kick_i = 1'b0;
      repeat (14) cyc();
    end
    check("wdt_kicked_ready", int'(ready_o), 1);
    wdt_kick_i = 1'b1; cyc(); wdt_kick_i = 1'b0;
    t0 = -1;
    for (int n = 1; n <= 40 && t0 < 0; n++) begin cyc(); if (reset_o == 3'b111) t0 = n; end
    check("wdt_fire_cycle", t0, 20);
    check("wdt_cause", int'(cause_o), 4);
    wait_ready("wdt_ready", 40);
`else
    repeat (40) cyc();
    check("no_wdt_ready", int'(ready_o), 1);
`endif

    // Randomised stimulus against the model
    lock_left = 0; btn_left = 0; kick_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) kick_on = ($urandom_range(0, 1) == 0);
      if (lock_left == 0 && $urandom_range(0, 199) == 0) lock_left = $urandom_range(1, 4);
      if (lock_left > 0) begin
        locked_i = 2'($urandom_range(0, 2));
        lock_left--;
      end else begin
        locked_i = 2'b11;
      end
      if (btn_left == 0 && $urandom_range(0, 149) == 0) btn_left = $urandom_range(1, 12);
      if (btn_left > 0) begin
        btn_n_i = 1'b0;
        btn_left--;
      end else begin
        btn_n_i = 1'b1;
      end
      sw_reset_i = ($urandom_range(0, 59) == 0);
      wdt_kick_i = kick_on && ($urandom_range(0, 7) == 0);
      cyc();
    end
    locked_i = 2'b11; btn_n_i = 1'b1; sw_reset_i = 1'b0; wdt_kick_i = 1'b0;
    cyc();

    chk_en = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
